// File: rtl/led_pattern_gen.sv
`default_nettype none
// led_pattern_gen: prescaled 4-mode LED pattern stepper with PWM brightness gating.
// Revision 1.0

module led_pattern_gen #(
    parameter int WIDTH     = 4,
    parameter int LOG2DELAY = 25,
    parameter int PWM_BITS  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    output logic [WIDTH-1:0]    led,
    output logic                tick
);

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [WIDTH-1:0] PAT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    mode_t                mode_q, mode_d, mode_in;
    dir_t                 dir_q, dir_d;
    logic [WIDTH-1:0]     pat_q, pat_d;
    logic [LOG2DELAY-1:0] presc_q, presc_d;
    logic [PWM_BITS-1:0]  pwm_q, pwm_d;
    logic [WIDTH-1:0]     led_d;
    logic                 tick_d;
    logic                 wrap;
    logic                 mode_chg;
    logic                 gate;

    always_comb begin
        mode_in  = mode_t'(mode);
        wrap     = en && (presc_q == '1);
        mode_chg = (mode_in != mode_q);
        gate     = (duty == '1) || (pwm_q < duty);
    end

    // A mode change wins over a coincident prescaler wrap: the pattern is
    // reinitialised, the prescaler restarts and no tick is emitted.
    always_comb begin
        mode_d  = mode_q;
        dir_d   = dir_q;
        pat_d   = pat_q;
        presc_d = presc_q;
        pwm_d   = pwm_q;
        tick_d  = 1'b0;
        led_d   = en ? (pat_q & {WIDTH{gate}}) : '0;

        if (en) begin
            pwm_d = pwm_q + 1'b1;
        end

        if (mode_chg) begin
            mode_d  = mode_in;
            presc_d = '0;
            case (mode_in)
                MODE_COUNT:  pat_d = '0;
                MODE_WALK:   pat_d = PAT_ONE;
                MODE_BOUNCE: begin
                    pat_d = PAT_ONE;
                    dir_d = DIR_UP;
                end
                default:     pat_d = pat_q;
            endcase
        end else if (en) begin
            presc_d = presc_q + 1'b1;
            if (wrap) begin
                tick_d = 1'b1;
                case (mode_q)
                    MODE_COUNT: pat_d = pat_q + 1'b1;
                    MODE_WALK: begin
                        if (pat_q == '0) pat_d = PAT_ONE;
                        else             pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
                    end
                    MODE_BOUNCE: begin
                        if (pat_q == '0) begin
                            pat_d = PAT_ONE;
                            dir_d = DIR_UP;
                        end else if (dir_q == DIR_UP) begin
                            if (pat_q[WIDTH-1]) begin
                                pat_d = pat_q >> 1;
                                dir_d = DIR_DOWN;
                            end else begin
                                pat_d = pat_q << 1;
                            end
                        end else begin
                            if (pat_q[0]) begin
                                pat_d = pat_q << 1;
                                dir_d = DIR_UP;
                            end else begin
                                pat_d = pat_q >> 1;
                            end
                        end
                    end
                    default: pat_d = pat_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= MODE_COUNT;
            dir_q   <= DIR_UP;
            pat_q   <= '0;
            presc_q <= '0;
            pwm_q   <= '0;
            tick    <= 1'b0;
            led     <= '0;
        end else begin
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            pat_q   <= pat_d;
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            tick    <= tick_d;
            led     <= led_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// tb_led_pattern_gen: directed self-checking bench for led_pattern_gen (WIDTH=4, LOG2DELAY=2, PWM_BITS=2).
// Revision 1.0

module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [1:0] duty;
    logic [3:0] led;
    logic       tick;

    int n_vec  = 0;
    int n_miss = 0;

    led_pattern_gen #(
        .WIDTH     (4),
        .LOG2DELAY (2),
        .PWM_BITS  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .duty  (duty),
        .led   (led),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until tick is seen (bounded); returns the number of edges taken.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick && n < 20);
        check_vec("tick_seen", {31'd0, tick}, 32'd1);
    endtask

    task automatic pwm_window(input logic [1:0] d, input int exp_on);
        int on  = 0;
        int bad = 0;
        duty = d;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            if (led == 4'b1010) on++;
            else if (led != 4'b0000) bad++;
        end
        check_vec("pwm_on", on, exp_on);
        check_vec("pwm_bad", bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int exp_walk[4]   = '{2, 4, 8, 1};
        int exp_bounce[4] = '{2, 4, 8, 4};
        int exp_tail[2]   = '{1, 2};

        rst_n = 1'b0; en = 1'b1; mode = 2'd1; duty = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            check_vec("rst_led", led, 0);
            check_vec("rst_tick", tick, 0);
        end
        mode  = 2'd0;
        rst_n = 1'b1;

        // COUNT: first tick four edges after release, then every 4 cycles
        wait_tick(n);
        check_vec("cnt_first", n, 4);
        for (int k = 1; k <= 16; k++) begin
            step();
            check_vec("cnt_led", led, k % 16);
            check_vec("cnt_tick_low", tick, 0);
            wait_tick(n);
            check_vec("cnt_per", n, 3);
        end

        // WALK
        mode = 2'd1;
        step();
        step();
        check_vec("walk_init", led, 1);
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            step();
            check_vec("walk_led", led, exp_walk[i]);
        end

        // Switch to BOUNCE on the very edge the prescaler wraps
        step();
        step();
        mode = 2'd2;
        step();
        check_vec("bnc_tick_supp", tick, 0);
        step();
        check_vec("bnc_init", led, 1);
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            step();
            check_vec("bnc_led", led, exp_bounce[i]);
        end

        // Freeze at pat=4 going down, prescaler at 1
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_vec("frz_led", led, 0);
            check_vec("frz_tick", tick, 0);
        end
        en = 1'b1;
        wait_tick(n);
        check_vec("frz_resume", n, 3);
        step();
        check_vec("frz_next", led, 2);
        for (int i = 0; i < 2; i++) begin
            wait_tick(n);
            step();
            check_vec("bnc_tail", led, exp_tail[i]);
        end

        // Reach 1010 via COUNT, then HOLD it for PWM
        mode = 2'd0;
        for (int i = 0; i < 10; i++) wait_tick(n);
        step();
        check_vec("pwm_pat", led, 4'b1010);
        mode = 2'd3;
        step();
        step();
        check_vec("hold_pat", led, 4'b1010);
        pwm_window(2'd0, 0);
        pwm_window(2'd1, 2);
        pwm_window(2'd2, 4);
        pwm_window(2'd3, 8);

        // Reset mid-COUNT at pat=9
        mode = 2'd0;
        for (int i = 0; i < 9; i++) wait_tick(n);
        step();
        check_vec("mid_pre", led, 9);
        rst_n = 1'b0;
        step();
        check_vec("mid_rst_led", led, 0);
        check_vec("mid_rst_tick", tick, 0);
        rst_n = 1'b1;
        wait_tick(n);
        check_vec("mid_presc0", n, 4);
        step();
        check_vec("mid_restart", led, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
